// File: rtl/apb_rr_scheduler.sv
// apb_rr_scheduler: round-robin arbiter that shares one APB completer among NUM_REQ requesters
module apb_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_rnw_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      err_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic [ADDR_W-1:0]         paddr_o,
    output logic                      pwrite_o,
    output logic [DATA_W-1:0]         pwdata_o,
    input  logic                      pready_i,
    input  logic [DATA_W-1:0]         prdata_i
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  rot;
    logic [PW-1:0]       sel;
    logic                found;
    logic                expired;
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata_i[g*DATA_W +: DATA_W];
    end

    // rotate requests so the pointer position sits at bit 0, then pick the lowest set bit
    always_comb begin
        rot   = NUM_REQ'({req_i, req_i} >> ptr_q);
        found = 1'b0;
        sel   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    // stall limit: this stalled ACCESS cycle is the TIMEOUT-th one
    assign expired = (TIMEOUT != 0) && !pready_i && (int'(cnt_q) + 1 >= TIMEOUT);

    // next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        gnt_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        rdata_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = SETUP;
                    idx_d      = sel;
                    ptr_d      = PW'((int'(sel) + 1) % NUM_REQ);
                    cnt_d      = '0;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    paddr_d    = addr_arr[sel];
                    pwrite_d   = ~req_rnw_i[sel];
                    pwdata_d   = wdata_arr[sel];
                    gnt_d[sel] = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (!pready_i)
                    cnt_d = (int'(cnt_q) >= TIMEOUT) ? cnt_q : cnt_q + CW'(1);
                if (pready_i || expired) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    paddr_d       = '0;
                    pwrite_d      = 1'b0;
                    pwdata_d      = '0;
                    done_d[idx_q] = 1'b1;
                    err_d         = ~pready_i;
                    rdata_d       = (pready_i && !pwrite_q) ? prdata_i : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset drops any transfer in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign paddr_o   = paddr_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// tb_apb_rr_scheduler: directed and randomized checks of the round-robin APB scheduler
module tb_apb_rr_scheduler;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N-1:0]    req_rnw_i = '0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N*DW-1:0] req_wdata_i = '0;
    logic [N-1:0]    gnt_o, done_o;
    logic            err_o, psel_o, penable_o, pwrite_o;
    logic [DW-1:0]   rdata_o, pwdata_o;
    logic [AW-1:0]   paddr_o;
    logic            pready_i = 1'b0;
    logic [DW-1:0]   prdata_i = '0;

    int ntests = 0;
    int nfail  = 0;
    int ptr    = 0;
    logic [AW-1:0] a_v [N];
    logic [DW-1:0] w_v [N];
    logic [N-1:0]  r_v;
    logic [DW-1:0] mem [int];

    apb_rr_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .req_rnw_i(req_rnw_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o),
        .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .psel_o(psel_o),
        .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .pready_i(pready_i), .prdata_i(prdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : (32'h5A5A_0000 ^ DW'(a));
    endfunction

    task automatic drive_cmds();
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW]  = a_v[i];
            req_wdata_i[i*DW +: DW] = w_v[i];
        end
        req_rnw_i = r_v;
    endtask

    task automatic xfer(input logic [N-1:0] mask, input logic [N-1:0] mid,
                        input int waits, input bit tmo, input bit rnd);
        int k;
        logic [DW-1:0] exp_rd;
        if (rnd)
            for (int i = 0; i < N; i++) begin
                a_v[i] = AW'($urandom_range(0, 1023));
                w_v[i] = $urandom;
                r_v[i] = 1'($urandom_range(0, 1));
            end
        drive_cmds();
        req_i = mask;
        k = pick(mask);
        @(negedge clk);
        chk("setup_gnt", gnt_o, 64'(1) << k);
        chk("setup_psel", {psel_o, penable_o}, 2'b10);
        chk("setup_paddr", paddr_o, a_v[k]);
        chk("setup_pwrite", pwrite_o, !r_v[k]);
        chk("setup_pwdata", pwdata_o, w_v[k]);
        chk("setup_done", done_o, 0);
        ptr = (k + 1) % N;
        req_i = mid;
        @(negedge clk);
        pready_i = 1'b0;
        prdata_i = $urandom;
        if (tmo) begin
            for (int c = 0; c < TO; c++) begin
                chk("tmo_access", {psel_o, penable_o, gnt_o, done_o}, {2'b11, 8'h00});
                @(negedge clk);
            end
            chk("tmo_psel", {psel_o, penable_o}, 2'b00);
            chk("tmo_done", done_o, 64'(1) << k);
            chk("tmo_err", err_o, 1'b1);
            chk("tmo_rdata", rdata_o, 0);
        end else begin
            for (int c = 0; c < waits; c++) begin
                chk("wait_access", {psel_o, penable_o, gnt_o, done_o}, {2'b11, 8'h00});
                @(negedge clk);
            end
            chk("last_access", {psel_o, penable_o, done_o}, {2'b11, 4'h0});
            chk("access_paddr", paddr_o, a_v[k]);
            pready_i = 1'b1;
            prdata_i = r_v[k] ? mem_rd(int'(a_v[k])) : $urandom;
            exp_rd   = r_v[k] ? prdata_i : '0;
            if (!r_v[k]) mem[int'(a_v[k])] = w_v[k];
            @(negedge clk);
            chk("done", done_o, 64'(1) << k);
            chk("done_err", err_o, 1'b0);
            chk("done_rdata", rdata_o, exp_rd);
            chk("done_idle", {psel_o, penable_o, gnt_o}, 6'h00);
        end
        pready_i = 1'b0;
        req_i = '0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            w_v[i] = '0;
        end
        r_v = '0;
        @(negedge clk);
        chk("rst_ctrl", {psel_o, penable_o, pwrite_o, err_o, gnt_o, done_o}, 12'h000);
        chk("rst_data", {rdata_o, pwdata_o, paddr_o}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_req", {psel_o, gnt_o}, 5'h00);

        a_v[0] = 10'h004; w_v[0] = 32'hA5A5_0001; r_v = 4'b0000;
        xfer(4'b0001, 4'b0000, 0, 1'b0, 1'b0);
        a_v[0] = 10'h008; r_v = 4'b0001; mem[8] = 32'h1234_5678;
        xfer(4'b0001, 4'b0000, 2, 1'b0, 1'b0);
        chk("read_value", rdata_o, 32'h1234_5678);

        for (int n = 0; n < 6; n++) xfer(4'b1111, 4'b1111, 0, 1'b0, 1'b1);
        xfer(4'b0100, 4'b0000, 1, 1'b0, 1'b1);
        xfer(4'b0101, 4'b0000, 0, 1'b0, 1'b1);
        xfer(4'b0101, 4'b0000, 0, 1'b0, 1'b1);
        xfer(4'b1000, 4'b0111, 0, 1'b0, 1'b1);
        xfer(4'b0100, 4'b0000, 0, 1'b0, 1'b1);

        xfer(4'b0010, 4'b0000, 0, 1'b1, 1'b1);
        xfer(4'b0010, 4'b0000, 1, 1'b0, 1'b1);
        xfer(4'b0001, 4'b0000, TO - 1, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++)
            xfer(N'($urandom_range(1, 15)), N'($urandom_range(0, 15)),
                 $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 1'b1);

        drive_cmds();
        req_i = 4'b0010;
        k = pick(req_i);
        @(negedge clk);
        chk("pre_rst_gnt", gnt_o, 64'(1) << k);
        req_i = '0;
        @(negedge clk);
        chk("pre_rst_access", {psel_o, penable_o}, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("async_rst", {psel_o, penable_o, gnt_o, done_o, err_o}, 11'h000);
        ptr = 0;
        @(negedge clk);
        chk("in_rst", {psel_o, done_o, err_o}, 6'h00);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_no_done", {done_o, err_o, psel_o}, 6'h00);
        xfer(4'b1111, 4'b0000, 0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
